fft_iter_r2: RTL and testbench
==============================

Name: fft_iter_r2

Overview:
- Sequential, in-place, radix-2 decimation-in-time FFT/IFFT engine for the audio_processing path.
- Supersedes the unrolled combinational recursive FFT: one shared butterfly is time-multiplexed over all stages.
- Generalised in N and W, with runtime forward/inverse selection, valid/ready streaming I/O, saturation and an overflow flag.
- Accepts one N-point complex frame, transforms it and streams out N bins in natural order.

Parameters:
- N, 256, transform length; power of two, 4..1024.
- W, 16, two's-complement width of each real/imag data word.
- TW, 16, twiddle word width; twiddles are Q2.(TW-2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts a sample.
- in_re  in  W  input real part.
- in_im  in  W  input imaginary part.
- inv  in  1  0 = forward, 1 = inverse; sampled with the first sample of a frame.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts a bin.
- out_re  out  W  bin real part.
- out_im  out  W  bin imaginary part.
- out_index  out  log2(N)  bin number k.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in COMPUTE or UNLOAD.
- ovf  out  1  sticky; set when any butterfly saturated in the current frame.

Behaviour:
- Reset (async assert, sync release):
  - State = LOAD, all counters 0.
  - in_ready=0, out_valid=0, out_last=0, busy=0, ovf=0, out_re/out_im/out_index=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- LOAD:
  - in_ready=1; a transfer is in_valid&in_ready.
  - Sample n is written to buffer address bitrev(n).
  - At n=0: latch inv and clear ovf.
  - After the N-th accept, go to COMPUTE on the next cycle; in_ready=0 from that edge.
- COMPUTE:
  - Stages s=0..log2N-1; butterflies b=0..N/2-1, exactly one per cycle.
  - Butterfly addressing: h=2^s, j=b mod h, top i=(b/h)*2h+j, bottom i+h.
  - Twiddle: k=j*N/(2h); w=cos(2πk/N) - i·sin(2πk/N); the sin sign is flipped when inv=1.
  - Twiddle ROM of N/2 entries is built at elaboration, rounded to nearest.
  - Product: full-precision complex multiply w·B, arithmetic-shifted right by TW-2 (floor).
  - Results: A' = A + wB, B' = A - wB, both written back the same cycle.
  - Compute latency is exactly (N/2)·log2N cycles, then go to UNLOAD.
- Arithmetic:
  - Sums are computed at W+2 bits and saturated to W bits (±(2^(W-1)-1), -2^(W-1)).
  - Any saturation sets ovf; ovf holds until the next frame's first accepted sample.
  - IFFT output is not divided by N unless the scaling option below is enabled.
- UNLOAD:
  - out_valid=1; out_re/out_im = buffer[k], out_index=k, k starts at 0.
  - k advances on out_valid&out_ready.
  - Data, index and out_last are held stable while out_ready=0.
  - After the k=N-1 transfer: out_valid=0 and state returns to LOAD (in_ready=1) on the same edge.
- Not supported: overlap of LOAD with UNLOAD. in_valid is ignored outside LOAD; out_ready is ignored outside UNLOAD.
- Reset in any state aborts the frame. The buffer contents are don't-care; no output is produced for the aborted frame.

Optional Feature:
- FFT_STAGE_SCALE_EN defined: each butterfly output is arithmetic-shifted right by 1 (floor) before saturation.
  - The overall result is DFT/N (forward) or exact IDFT (inverse).
  - Saturation and ovf logic remain present.
- Undefined: no per-stage shift; growth is handled only by saturation and ovf.

Test Plan:
- Reset: hold rst_n=0 mid-COMPUTE (N=8, W=16) -> all outputs 0 immediately. After release, in_ready=1 one edge later and a fresh frame transforms correctly.
- Impulse, N=8, no scaling: x[0]=1000, others 0, inv=0 -> all 8 bins = 1000+0i; out_index 0..7; out_last only at k=7.
- DC, N=8: all x=100+0i -> X[0]=800, X[1..7]=0, ovf=0. With FFT_STAGE_SCALE_EN -> X[0]=100, others 0.
- Round trip, N=8 with FFT_STAGE_SCALE_EN: forward then feed bins back with inv=1 -> x=[0,1000,2000,...,7000]·(1/8) recovered within ±2 LSB per component.
- Backpressure: out_ready toggling 1,0,0,1 pattern -> every bin delivered exactly once, values and index stable while stalled, COMPUTE length exactly 12 cycles for N=8.
- Overflow, no scaling, N=8: all x=20000 -> X[0]=32767 (saturated), ovf=1. The next frame of zeros clears ovf at its first accepted sample.

Source files
------------

// File: rtl/fft_iter_r2.sv
// fft_iter_r2: in-place radix-2 DIT FFT/IFFT with one time-shared butterfly.
// Define FFT_STAGE_SCALE_EN to halve every butterfly output (result scaled by 1/N).
module fft_iter_r2 #(
    parameter int N  = 256,
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_re,
    input  logic [W-1:0]         in_im,
    input  logic                 inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_re,
    output logic [W-1:0]         out_im,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 ovf
);
    localparam int LOGN = $clog2(N);
    localparam int SW   = $clog2(LOGN + 1);
    localparam int TKW  = LOGN - 1;
    localparam int HALF = N / 2;
    localparam int PW   = W + TW + 1;
    localparam int SUMW = W + 2;
    localparam logic signed [SUMW-1:0] SMAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SUMW-1:0] SMIN = {3'b111, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    function automatic logic sat_hit(input logic signed [SUMW-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    function automatic logic [W-1:0] sat_val(input logic signed [SUMW-1:0] v);
        logic [W-1:0] r;
        if (v > SMAX) begin
            r = {1'b0, {(W-1){1'b1}}};
        end else if (v < SMIN) begin
            r = {1'b1, {(W-1){1'b0}}};
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    // Round-to-nearest quantisation of a real twiddle into Q2.(TW-2).
    function automatic int tw_round(input real v);
        real sc;
        sc = v * real'(2 ** (TW - 2));
        if (sc >= 0.0) begin
            return $rtoi(sc + 0.5);
        end else begin
            return -$rtoi(0.5 - sc);
        end
    endfunction

    logic signed [TW-1:0] rom_cos_s [HALF];
    logic signed [TW-1:0] rom_sin_s [HALF];

    for (genvar g = 0; g < HALF; g++) begin : g_rom
        localparam real ANG = 6.283185307179586 * real'(g) / real'(N);
        localparam int  CV  = tw_round($cos(ANG));
        localparam int  SV  = tw_round($sin(ANG));
        assign rom_cos_s[g] = TW'(CV);
        assign rom_sin_s[g] = TW'(SV);
    end

    state_t          state_r;
    logic [LOGN-1:0] n_r;
    logic [LOGN-1:0] bfly_r;
    logic [SW-1:0]   stage_r;
    logic            inv_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            out_last_r;
    logic [LOGN-1:0] out_index_r;
    logic            busy_r;
    logic            ovf_r;
    logic [W-1:0]    mem_re_r [N];
    logic [W-1:0]    mem_im_r [N];

    logic [LOGN-1:0]        h_s, j_s, top_s, bot_s;
    logic [TKW-1:0]         tk_s;
    logic signed [TW-1:0]   wr_s, wi_s;
    logic signed [W-1:0]    ar_s, ai_s, br_s, bi_s;
    logic signed [PW-1:0]   pr_s, pi_s;
    logic signed [SUMW-1:0] tr_s, ti_s, ax_s, aix_s;
    logic signed [SUMW-1:0] str_s, sti_s, sbr_s, sbi_s;
    logic                   bfly_ovf_s;

    // Butterfly datapath: address generation, twiddle lookup, multiply, add/sub.
    always_comb begin
        h_s   = LOGN'(1) << stage_r;
        j_s   = bfly_r & (h_s - LOGN'(1));
        top_s = ((bfly_r >> stage_r) << (stage_r + SW'(1))) | j_s;
        bot_s = top_s | h_s;
        tk_s  = TKW'(j_s << (SW'(LOGN - 1) - stage_r));
        wr_s  = rom_cos_s[tk_s];
        wi_s  = inv_r ? rom_sin_s[tk_s] : -rom_sin_s[tk_s];
        ar_s  = mem_re_r[top_s];
        ai_s  = mem_im_r[top_s];
        br_s  = mem_re_r[bot_s];
        bi_s  = mem_im_r[bot_s];
        pr_s  = PW'(br_s) * PW'(wr_s) - PW'(bi_s) * PW'(wi_s);
        pi_s  = PW'(br_s) * PW'(wi_s) + PW'(bi_s) * PW'(wr_s);
        // |w*B| per component stays below 2^W, so W+2 bits hold it without loss.
        tr_s  = SUMW'(pr_s >>> (TW - 2));
        ti_s  = SUMW'(pi_s >>> (TW - 2));
        ax_s  = SUMW'(ar_s);
        aix_s = SUMW'(ai_s);
        str_s = ax_s + tr_s;
        sti_s = aix_s + ti_s;
        sbr_s = ax_s - tr_s;
        sbi_s = aix_s - ti_s;
`ifdef FFT_STAGE_SCALE_EN
        str_s = str_s >>> 1;
        sti_s = sti_s >>> 1;
        sbr_s = sbr_s >>> 1;
        sbi_s = sbi_s >>> 1;
`else
        str_s = str_s;
`endif
        bfly_ovf_s = sat_hit(str_s) | sat_hit(sti_s) | sat_hit(sbr_s) | sat_hit(sbi_s);
    end

    // Sample buffer: bit-reversed loading and in-place butterfly write-back.
    always_ff @(posedge clk) begin
        if ((state_r == ST_LOAD) && in_valid && in_ready_r) begin
            mem_re_r[bitrev(n_r)] <= in_re;
            mem_im_r[bitrev(n_r)] <= in_im;
        end else if (state_r == ST_COMPUTE) begin
            mem_re_r[top_s] <= sat_val(str_s);
            mem_im_r[top_s] <= sat_val(sti_s);
            mem_re_r[bot_s] <= sat_val(sbr_s);
            mem_im_r[bot_s] <= sat_val(sbi_s);
        end
    end

    // Frame sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            n_r         <= LOGN'(0);
            bfly_r      <= LOGN'(0);
            stage_r     <= SW'(0);
            inv_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_index_r <= LOGN'(0);
            busy_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        if (n_r == LOGN'(0)) begin
                            inv_r <= inv;
                            ovf_r <= 1'b0;
                        end
                        if (n_r == LOGN'(N - 1)) begin
                            state_r    <= ST_COMPUTE;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                            n_r        <= LOGN'(0);
                            bfly_r     <= LOGN'(0);
                            stage_r    <= SW'(0);
                        end else begin
                            n_r <= n_r + LOGN'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (bfly_ovf_s) begin
                        ovf_r <= 1'b1;
                    end
                    if (bfly_r == LOGN'(HALF - 1)) begin
                        bfly_r <= LOGN'(0);
                        if (stage_r == SW'(LOGN - 1)) begin
                            stage_r     <= SW'(0);
                            state_r     <= ST_UNLOAD;
                            out_valid_r <= 1'b1;
                            out_index_r <= LOGN'(0);
                            out_last_r  <= 1'b0;
                        end else begin
                            stage_r <= stage_r + SW'(1);
                        end
                    end else begin
                        bfly_r <= bfly_r + LOGN'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (out_index_r == LOGN'(N - 1)) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_index_r <= LOGN'(0);
                            busy_r      <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= ST_LOAD;
                        end else begin
                            out_index_r <= out_index_r + LOGN'(1);
                            out_last_r  <= (out_index_r == LOGN'(N - 2));
                        end
                    end
                end
                default: begin
                    state_r     <= ST_LOAD;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_index = out_index_r;
    assign busy      = busy_r;
    assign ovf       = ovf_r;
    assign out_re    = out_valid_r ? mem_re_r[out_index_r] : W'(0);
    assign out_im    = out_valid_r ? mem_im_r[out_index_r] : W'(0);

endmodule

// File: tb/tb_fft_iter_r2.sv
// Self-checking bench for fft_iter_r2 (N=8): vector table, corner sequences, random frames vs DFT model.
module tb_fft_iter_r2;
    localparam int N    = 8;
    localparam int W    = 16;
    localparam int TW   = 16;
    localparam int LOGN = 3;
`ifdef FFT_STAGE_SCALE_EN
    localparam int IMP_X = 125;
    localparam int DC_X0 = 100;
    localparam int ALT_X = 1000;
    localparam int OV_X0 = 20000;
    localparam bit OV_F  = 1'b0;
`else
    localparam int IMP_X = 1000;
    localparam int DC_X0 = 800;
    localparam int ALT_X = 8000;
    localparam int OV_X0 = 32767;
    localparam bit OV_F  = 1'b1;
`endif

    logic            clk = 1'b0;
    logic            rst_n, in_valid, in_ready, inv, out_valid, out_ready, out_last, busy, ovf;
    logic [W-1:0]    in_re, in_im, out_re, out_im;
    logic [LOGN-1:0] out_index;

    always #5 clk = ~clk;

    fft_iter_r2 #(.N(N), .W(W), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .inv(inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_index(out_index), .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    typedef struct {
        string                   name;
        logic [N-1:0][W-1:0]     xr;
        logic                    inv;
        logic [N-1:0][W-1:0]     er;
        logic                    ovf;
    } vec_t;

    vec_t tbl[5];
    int   nvec, nerr;
    int   fr_re[N], fr_im[N], got_re[N], got_im[N], ex_re[N], ex_im[N], keep[N];
    bit   fr_inv;
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        nvec++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // Plain DFT of the current frame; both directions carry a 1/N factor when scaled.
    task automatic model();
        for (int k = 0; k < N; k++) begin
            real sr, si, ang;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = 6.283185307179586 * real'(n * k) / real'(N);
                if (!fr_inv) ang = -ang;
                sr += real'(fr_re[n]) * $cos(ang) - real'(fr_im[n]) * $sin(ang);
                si += real'(fr_re[n]) * $sin(ang) + real'(fr_im[n]) * $cos(ang);
            end
`ifdef FFT_STAGE_SCALE_EN
            sr = sr / real'(N);
            si = si / real'(N);
`endif
            ex_re[k] = rnd(sr);
            ex_im[k] = rnd(si);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0, 0);
        chk({tag, "_out_valid"}, out_valid, 0, 0);
        chk({tag, "_out_last"}, out_last, 0, 0);
        chk({tag, "_busy"}, busy, 0, 0);
        chk({tag, "_ovf"}, ovf, 0, 0);
        chk({tag, "_out_re"}, int'(out_re), 0, 0);
        chk({tag, "_out_im"}, int'(out_im), 0, 0);
        chk({tag, "_out_index"}, int'(out_index), 0, 0);
    endtask

    // Starts and ends #1 after a rising edge.
    task automatic send_frame(input bit gaps);
        for (int n = 0; n < N; n++) begin
            int cyc;
            bit ok;
            if (gaps && ($urandom_range(3, 0) == 0)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_re    = W'(fr_re[n]);
            in_im    = W'(fr_im[n]);
            inv      = (n == 0) ? fr_inv : 1'($urandom_range(1, 0));
            cyc = 0;
            ok  = 1'b0;
            while (!ok && cyc < 100) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!ok) chk("load_timeout", 0, 1, 0);
            if (n == 0) chk("ovf_clear_first_accept", ovf, 0, 0);
        end
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        chk("in_ready_drop", in_ready, 0, 0);
    endtask

    // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random.
    task automatic recv_frame(input int mode);
        int k, cyc, clen, bad, pr, pim;
        bit stalled, rdy;
        clen = 0;
        bad  = 0;
        cyc  = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (out_valid) break;
            clen++;
            cyc++;
            if (!busy || in_ready) bad++;
        end
        chk("compute_len", clen, (N / 2) * LOGN, 0);
        chk("busy_ready_in_compute", bad, 0, 0);
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        pr = 0;
        pim = 0;
        while (k < N && cyc < 400) begin
            chk("out_valid", out_valid, 1, 0);
            chk("out_index", int'(out_index), k, 0);
            chk("out_last", out_last, (k == N - 1) ? 1 : 0, 0);
            if (stalled) begin
                chk("hold_re", int'($signed(out_re)), pr, 0);
                chk("hold_im", int'($signed(out_im)), pim, 0);
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(1, 0));
            out_ready = rdy;
            if (rdy) begin
                got_re[k] = int'($signed(out_re));
                got_im[k] = int'($signed(out_im));
                k++;
                stalled = 1'b0;
            end else begin
                pr = int'($signed(out_re));
                pim = int'($signed(out_im));
                stalled = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("unload_count", k, N, 0);
        chk("out_valid_after", out_valid, 0, 0);
        chk("in_ready_after", in_ready, 1, 0);
        chk("busy_after", busy, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic cmp_model(input string tag, input int tol);
        model();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_re%0d", tag, k), got_re[k], ex_re[k], tol);
            chk($sformatf("%s_im%0d", tag, k), got_im[k], ex_im[k], tol);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; inv = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            tbl[0].xr[i] = (i == 0) ? W'(1000) : W'(0);
            tbl[0].er[i] = W'(IMP_X);
            tbl[1].xr[i] = W'(100);
            tbl[1].er[i] = (i == 0) ? W'(DC_X0) : W'(0);
            tbl[2].xr[i] = (i % 2 == 0) ? W'(1000) : W'(-1000);
            tbl[2].er[i] = (i == 4) ? W'(ALT_X) : W'(0);
            tbl[3].xr[i] = W'(20000);
            tbl[3].er[i] = (i == 0) ? W'(OV_X0) : W'(0);
            tbl[4].xr[i] = W'(0);
            tbl[4].er[i] = W'(0);
        end
        tbl[0].name = "impulse";  tbl[0].inv = 1'b0; tbl[0].ovf = 1'b0;
        tbl[1].name = "dc";       tbl[1].inv = 1'b0; tbl[1].ovf = 1'b0;
        tbl[2].name = "alt";      tbl[2].inv = 1'b0; tbl[2].ovf = 1'b0;
        tbl[3].name = "overflow"; tbl[3].inv = 1'b0; tbl[3].ovf = OV_F;
        tbl[4].name = "zeros";    tbl[4].inv = 1'b0; tbl[4].ovf = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); chk("ready_before_edge", in_ready, 0, 0);
        @(negedge clk); chk("ready_after_edge", in_ready, 1, 0);
        @(posedge clk); #1;

        // Abort a frame mid-compute.
        for (int i = 0; i < N; i++) begin fr_re[i] = 20000; fr_im[i] = 0; end
        fr_inv = 1'b0;
        send_frame(1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_pre_abort", ovf, OV_F, 0);
        chk("busy_pre_abort", busy, 1, 0);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(negedge clk); chk("ready_before_edge2", in_ready, 0, 0);
        @(negedge clk); chk("ready_after_edge2", in_ready, 1, 0);
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++) begin
                fr_re[i] = int'($signed(tbl[t].xr[i]));
                fr_im[i] = 0;
            end
            fr_inv = tbl[t].inv;
            send_frame(1'b0);
            recv_frame(0);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("%s_re%0d", tbl[t].name, i), got_re[i], int'($signed(tbl[t].er[i])), 0);
                chk($sformatf("%s_im%0d", tbl[t].name, i), got_im[i], 0, 0);
            end
            chk({tbl[t].name, "_ovf"}, ovf, tbl[t].ovf, 0);
        end

        // Round trip: forward, then feed the bins back as an inverse frame.
        for (int i = 0; i < N; i++) begin
`ifdef FFT_STAGE_SCALE_EN
            fr_re[i] = 1000 * i;
`else
            fr_re[i] = 100 * i;
`endif
            fr_im[i] = 0;
            keep[i]  = fr_re[i];
        end
        fr_inv = 1'b0;
        send_frame(1'b0);
        recv_frame(0);
        cmp_model("rt_fwd", 3);
        for (int i = 0; i < N; i++) begin fr_re[i] = got_re[i]; fr_im[i] = got_im[i]; end
        fr_inv = 1'b1;
        send_frame(1'b0);
        recv_frame(0);
`ifdef FFT_STAGE_SCALE_EN
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rt_inv_re%0d", i), got_re[i], keep[i] / N, 2);
            chk($sformatf("rt_inv_im%0d", i), got_im[i], 0, 2);
        end
`else
        cmp_model("rt_inv", 3);
`endif

        // Backpressure with the 1,0,0,1 ready pattern.
        for (int i = 0; i < N; i++) begin
            fr_re[i] = int'($urandom_range(4000, 0)) - 2000;
            fr_im[i] = int'($urandom_range(4000, 0)) - 2000;
        end
        fr_inv = 1'b0;
        send_frame(1'b0);
        recv_frame(1);
        cmp_model("bp", 3);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                fr_re[i] = int'($urandom_range(4000, 0)) - 2000;
                fr_im[i] = int'($urandom_range(4000, 0)) - 2000;
            end
            fr_inv = 1'($urandom_range(1, 0));
            send_frame(1'b1);
            recv_frame(2);
            cmp_model($sformatf("rand%0d", f), 3);
            chk("rand_ovf", ovf, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
